// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the F/D memory port arbiter: state encoding and
// mux select values.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_F = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam logic SEL_FETCH = 1'b0;
    localparam logic SEL_DATA  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_timeout_counter.sv
// Transaction watchdog: counts enabled cycles and flags expiry at limit-1,
// so an abort on the following edge lands exactly limit cycles in.
module arb_timeout_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt;

    // A zero limit disables the watchdog entirely.
    assign expired = (limit != '0) && (cnt == limit - ONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared memory port between instruction fetch (F)
// and load/store (D), with req/ack sequencing and a per-transaction timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic f_req,
    input  logic d_req,
    input  logic d_we,
    input  logic mem_ack,
    output logic mem_sel,
    output logic mem_req,
    output logic mem_we,
    output logic f_done,
    output logic d_done,
    output logic busy,
    output logic timeout_err
);

    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYC);

    arb_state_t state, state_nxt;
    logic       last_grant, last_grant_nxt;
    logic       mem_sel_nxt, mem_req_nxt, mem_we_nxt;
    logic       f_done_nxt, d_done_nxt, busy_nxt, timeout_err_nxt;
    logic       f_win, d_win, gsel, expired, in_busy, tmo_hit;

    // A requester still shows req during its own done cycle; it must not
    // be re-granted for a transaction that has just completed.
    assign f_win   = f_req && !f_done;
    assign d_win   = d_req && !d_done;
    assign gsel    = (f_win && d_win) ? ~last_grant : d_win;
    assign in_busy = (state == BUSY_F) || (state == BUSY_D);
    assign tmo_hit = in_busy && expired && !mem_ack;

    arb_timeout_counter #(
        .CNT_W(CNT_W)
    ) u_tmo (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (!in_busy || mem_ack),
        .en     (in_busy),
        .limit  (TMO_LIMIT),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_grant  <= SEL_DATA;
            mem_sel     <= SEL_FETCH;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            f_done      <= 1'b0;
            d_done      <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            last_grant  <= last_grant_nxt;
            mem_sel     <= mem_sel_nxt;
            mem_req     <= mem_req_nxt;
            mem_we      <= mem_we_nxt;
            f_done      <= f_done_nxt;
            d_done      <= d_done_nxt;
            busy        <= busy_nxt;
            timeout_err <= timeout_err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (f_win || d_win) begin
                    state_nxt      = (gsel == SEL_DATA) ? BUSY_D : BUSY_F;
                    last_grant_nxt = gsel;
                end
            end
            BUSY_F, BUSY_D: begin
                // Ack takes priority over a coincident expiry.
                if (mem_ack || expired) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_sel_nxt     = mem_sel;
        mem_we_nxt      = mem_we;
        mem_req_nxt     = (state_nxt != IDLE);
        busy_nxt        = (state_nxt != IDLE);
        f_done_nxt      = (state == BUSY_F) && (state_nxt == IDLE);
        d_done_nxt      = (state == BUSY_D) && (state_nxt == IDLE);
        timeout_err_nxt = timeout_err || tmo_hit;
        if ((state == IDLE) && (state_nxt != IDLE)) begin
            mem_sel_nxt = gsel;
            mem_we_nxt  = (gsel == SEL_DATA) && d_we;
        end else if (state_nxt == IDLE) begin
            mem_we_nxt = 1'b0;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates one shared 32-bit memory port between the instruction-fetch requester (F) and the load/store requester (D) in the MIPS core.
Drives the select line of the existing 2:1 address and write-data muxes: mem_sel=1 selects the D side (ifone), mem_sel=0 selects the F side (ifzero).
Sequences each transaction with a req/ack handshake to memory and a done pulse back to the winning requester.
Round-robin fairness between F and D; a per-transaction timeout flags a hung memory.

Parameters:
TIMEOUT_CYC, 64, busy cycles without mem_ack before abort; 0 disables the timeout
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
f_req  in  1  fetch request; held high until f_done
d_req  in  1  data request; held high until d_done
d_we  in  1  data request is a write; stable while d_req is high
mem_ack  in  1  memory completion, single-cycle pulse
mem_sel  out  1  mux select: 0 = F, 1 = D
mem_req  out  1  request to memory
mem_we  out  1  write enable to memory
f_done  out  1  one-cycle completion pulse to F
d_done  out  1  one-cycle completion pulse to D
busy  out  1  high in any BUSY state
timeout_err  out  1  sticky; cleared only by reset

Behaviour:
- Design style: one clock domain. All outputs are registered. reset_n is asynchronous and active-low.
- Reset values: state=IDLE, mem_sel=0, mem_req=0, mem_we=0, f_done=0, d_done=0, busy=0, timeout_err=0, last_grant=1 (so F wins the first tie), counter=0.
- States: IDLE, BUSY_F, BUSY_D.
- IDLE, no request: stay in IDLE.
- IDLE, f_req only: go to BUSY_F, mem_sel<=0, mem_we<=0.
- IDLE, d_req only: go to BUSY_D, mem_sel<=1, mem_we<=d_we.
- IDLE, both requests: grant the side opposite last_grant, then update last_grant.
- Grant latency: a request sampled at edge N gives mem_req=1 and busy=1 after edge N; mem_sel is valid in the same cycle.
- BUSY_x: mem_req, mem_sel and mem_we are held constant. Requesters hold their address and data stable; these pass through the external muxes combinationally.
- mem_ack sampled in BUSY_x at edge M: after edge M, mem_req=0, x_done=1 for exactly one cycle, state=IDLE, counter=0.
- Memory read data is broadcast to both requesters. Each requester captures it on its own done pulse.
- Back-to-back: the IDLE cycle after done re-arbitrates, giving a minimum 1-cycle bubble between memory requests. Under continuous contention, grants strictly alternate F, D, F, D.
- Requester drops req during BUSY: this is a protocol violation. It is ignored; the transaction completes and done still pulses.
- mem_ack in IDLE: ignored, with no state change.
- Timeout (TIMEOUT_CYC>0): counter increments each BUSY cycle without mem_ack. When it reaches TIMEOUT_CYC-1 without mem_ack, the next edge does the following:
  - mem_req drops;
  - x_done pulses;
  - timeout_err is set;
  - state returns to IDLE.
- mem_ack on the same edge as the timeout: ack wins, normal completion, timeout_err is not set.
- reset_n asserted mid-transaction: all outputs go immediately to reset values and any in-flight transaction is dropped. Memory must also be reset.

Decomposition:
- Shared package:
  - state encoding (IDLE=2'd0, BUSY_F=2'd1, BUSY_D=2'd2);
  - SEL_FETCH=1'b0, SEL_DATA=1'b1.
- Sub-module arb_timeout_counter: clear/enable/limit inputs and an expired output, reusable for other bus masters.
- Address and write-data muxing stays outside, in two existing 32-bit 2:1 mux instances driven by mem_sel.

Test Plan:
- Single fetch: after reset, f_req=1; mem_ack 3 cycles after mem_req rises -> mem_sel=0, mem_we=0, mem_req high exactly 3 cycles, f_done 1-cycle pulse the cycle after ack.
- Tie after reset: f_req and d_req rise on the same edge, held -> F served first (mem_sel=0), then D (mem_sel=1), with exactly one IDLE cycle between them.
- Sustained contention: both requests held for 6 transactions, ack latency 1 -> grant order F,D,F,D,F,D and done pulses alternate.
- Data write: d_req=1, d_we=1 -> mem_sel=1 and mem_we=1 for the whole BUSY_D; a following F grant shows mem_we=0.
- Timeout: TIMEOUT_CYC=8, d_req with no ack -> mem_req high for 8 cycles then low, d_done pulses, timeout_err=1 and stays 1. A later F transaction completes normally.
- Async reset: reset_n pulled low mid-BUSY_D between clock edges -> mem_req, mem_sel, busy and done go to 0 immediately. After release, a pending f_req wins first.
